// File: rtl/coo_row_dispatcher_pkg.sv
// Shared types for the COO row dispatcher: element payload, FSM states, mode codes.
package coo_pkg;

    localparam int COO_DATA_W = 32;
    localparam int COO_IDX_W  = 16;

    // Target selection modes
    localparam int MODE_MOD = 0;
    localparam int MODE_RR  = 1;

    // Default-width element; the dispatcher builds its own copy at its parameter widths
    typedef struct packed {
        logic [COO_DATA_W-1:0] val;
        logic [COO_IDX_W-1:0]  row;
        logic [COO_IDX_W-1:0]  col;
        logic                  row_last;
        logic                  stream_last;
    } coo_elem_t;

    typedef enum logic [2:0] {
        EMPTY = 3'd0,
        HOLD  = 3'd1,
        FLUSH = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } disp_state_t;

endpackage

// File: rtl/coo_row_dispatcher_fifo.sv
// Per-PE element FIFO: registered full/empty, no fall-through, head zeroed when empty.
module coo_fifo
    import coo_pkg::*;
#(
    parameter type T     = coo_elem_t,
    parameter int  DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;
    logic          r_full;
    logic          r_empty;

    logic          w_do_push;
    logic          w_do_pop;
    logic [AW:0]   w_cnt_nxt;

    assign w_do_push = i_push && !r_full;
    assign w_do_pop  = i_pop && !r_empty;

    // Occupancy after this cycle's push/pop; flags are registered from it
    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_do_push, w_do_pop})
            2'b10:   w_cnt_nxt = r_cnt + 1'b1;
            2'b01:   w_cnt_nxt = r_cnt - 1'b1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Pointers and status flags; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_cnt   <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_cnt_nxt == '0);
        end
    end

    // Storage write; contents are don't-care until pointed at, so no reset
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_empty ? T'('0) : r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/coo_row_dispatcher.sv
// Row-sorted COO stream to per-PE FIFOs, with one-element look-ahead for row_last tagging.
module coo_row_dispatcher
    import coo_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int IDX_W      = 16,
    parameter int NUM_PES    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int MODE       = 0,
    parameter int CNT_W      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_val,
    input  logic [IDX_W-1:0]          in_row,
    input  logic [IDX_W-1:0]          in_col,
    input  logic                      in_last,
    output logic [NUM_PES-1:0]        out_valid,
    input  logic [NUM_PES-1:0]        out_ready,
    output logic [NUM_PES*DATA_W-1:0] out_val,
    output logic [NUM_PES*IDX_W-1:0]  out_row,
    output logic [NUM_PES*IDX_W-1:0]  out_col,
    output logic [NUM_PES-1:0]        out_row_last,
    output logic [NUM_PES-1:0]        out_stream_last,
    output logic                      done,
    output logic                      err_order,
    output logic [CNT_W-1:0]          rows_cnt
);

    localparam int              PE_W    = (NUM_PES > 1) ? $clog2(NUM_PES) : 1;
    localparam logic [PE_W-1:0] PE_MASK = PE_W'(NUM_PES - 1);

    typedef struct packed {
        logic [DATA_W-1:0] val;
        logic [IDX_W-1:0]  row;
        logic [IDX_W-1:0]  col;
        logic              row_last;
        logic              stream_last;
    } elem_t;

    disp_state_t       r_state;
    disp_state_t       w_state_nxt;

    // Look-ahead hold register
    logic              r_h_valid;
    logic [DATA_W-1:0] r_h_val;
    logic [IDX_W-1:0]  r_h_row;
    logic [IDX_W-1:0]  r_h_col;
    logic [PE_W-1:0]   r_h_pe;

    logic [CNT_W-1:0]  r_rows_cnt;
    logic              r_err;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_first;
    logic              w_new_row;
    logic              w_flush_go;
    logic              w_push;
    logic              w_push_rl;
    logic              w_push_sl;
    logic [PE_W-1:0]   w_cap_pe;
    elem_t             w_push_elem;
    logic [NUM_PES-1:0] w_full;
    logic [NUM_PES-1:0] w_empty;
    logic [NUM_PES-1:0] w_push_vec;

    assign w_first    = (r_state == EMPTY) || (r_state == DONE);
    assign w_new_row  = (in_row != r_h_row);
    assign w_flush_go = (r_state == FLUSH) && !w_full[r_h_pe];

    // Input acceptance: HOLD back-pressures only on the held element's target FIFO
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            EMPTY, DONE: w_in_ready = 1'b1;
            HOLD:        w_in_ready = !w_full[r_h_pe];
            default:     w_in_ready = 1'b0;
        endcase
    end

    assign in_ready = w_in_ready && !rst;
    assign w_accept = in_valid && in_ready;

    // Target PE for the element being captured; round-robin restarts at PE 0 per stream
    always_comb begin
        w_cap_pe = r_h_pe;
        if (MODE == MODE_RR) begin
            if (w_first)        w_cap_pe = '0;
            else if (w_new_row) w_cap_pe = (r_h_pe + 1'b1) & PE_MASK;
            else                w_cap_pe = r_h_pe;
        end else begin
            w_cap_pe = in_row[PE_W-1:0] & PE_MASK;
        end
    end

    // The held element leaves when its successor arrives or when the stream is flushed
    always_comb begin
        w_push    = 1'b0;
        w_push_rl = 1'b0;
        w_push_sl = 1'b0;
        case (r_state)
            HOLD: begin
                if (w_accept) begin
                    w_push    = 1'b1;
                    w_push_rl = w_new_row;
                end
            end
            FLUSH: begin
                if (!w_full[r_h_pe]) begin
                    w_push    = 1'b1;
                    w_push_rl = 1'b1;
                    w_push_sl = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign w_push_elem = '{val:         r_h_val,
                           row:         r_h_row,
                           col:         r_h_col,
                           row_last:    w_push_rl,
                           stream_last: w_push_sl};

    // Dispatcher state transitions
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY, DONE: if (w_accept) w_state_nxt = in_last ? FLUSH : HOLD;
            HOLD:        if (w_accept && in_last) w_state_nxt = FLUSH;
            FLUSH:       if (w_flush_go) w_state_nxt = DRAIN;
            DRAIN:       if (&w_empty) w_state_nxt = DONE;
            default:     w_state_nxt = EMPTY;
        endcase
    end

    // State, hold register, sticky order error and row counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_h_valid  <= 1'b0;
            r_h_val    <= '0;
            r_h_row    <= '0;
            r_h_col    <= '0;
            r_h_pe     <= '0;
            r_rows_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_h_valid <= 1'b1;
                r_h_val   <= in_val;
                r_h_row   <= in_row;
                r_h_col   <= in_col;
                r_h_pe    <= w_cap_pe;
            end else if (w_flush_go) begin
                r_h_valid <= 1'b0;
            end
            if (w_accept && r_h_valid && (in_row < r_h_row)) r_err <= 1'b1;
            if (w_push && w_push_rl) r_rows_cnt <= r_rows_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_PES; g++) begin : g_pe
        elem_t w_head;

        assign w_push_vec[g] = w_push && (r_h_pe == PE_W'(g));

        coo_fifo #(
            .T     (elem_t),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_push_vec[g]),
            .i_data  (w_push_elem),
            .i_pop   (out_ready[g]),
            .o_data  (w_head),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g])
        );

        assign out_valid[g]                 = !w_empty[g];
        assign out_val[g*DATA_W +: DATA_W]  = w_head.val;
        assign out_row[g*IDX_W +: IDX_W]    = w_head.row;
        assign out_col[g*IDX_W +: IDX_W]    = w_head.col;
        assign out_row_last[g]              = w_head.row_last;
        assign out_stream_last[g]           = w_head.stream_last;
    end

    assign done      = (r_state == DONE);
    assign err_order = r_err;
    assign rows_cnt  = r_rows_cnt;

endmodule

// File: tb/tb_coo_row_dispatcher.sv
// Bench for coo_row_dispatcher: a MODE 0 and a MODE 1 instance, per-PE scoreboard queues.
module tb_coo_row_dispatcher;

    typedef struct packed {
        logic [31:0] val;
        logic [15:0] row;
        logic [15:0] col;
        logic        rl;
        logic        sl;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic         iv_m, ir_m, il_m;
    logic [31:0]  ival_m;
    logic [15:0]  irow_m, icol_m;
    logic [3:0]   ov_m, ordy_m, orl_m, osl_m;
    logic [127:0] oval_m;
    logic [63:0]  orow_m, ocol_m;
    logic         done_m, err_m;
    logic [31:0]  cnt_m;

    logic         iv_r, ir_r, il_r;
    logic [31:0]  ival_r;
    logic [15:0]  irow_r, icol_r;
    logic [3:0]   ov_r, ordy_r, orl_r, osl_r;
    logic [127:0] oval_r;
    logic [63:0]  orow_r, ocol_r;
    logic         done_r, err_r;
    logic [31:0]  cnt_r;

    exp_t sbq [8][$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   s_row  [20];
    exp_t e_arr  [20];
    int   pe_arr [20];
    int   seq = 0;
    int   k;

    always #5 clk = ~clk;

    coo_row_dispatcher #(.DATA_W(32), .IDX_W(16), .NUM_PES(4), .FIFO_DEPTH(8), .MODE(0), .CNT_W(32)) u_mod (
        .clk(clk), .rst(rst), .in_valid(iv_m), .in_ready(ir_m), .in_val(ival_m), .in_row(irow_m),
        .in_col(icol_m), .in_last(il_m), .out_valid(ov_m), .out_ready(ordy_m), .out_val(oval_m),
        .out_row(orow_m), .out_col(ocol_m), .out_row_last(orl_m), .out_stream_last(osl_m),
        .done(done_m), .err_order(err_m), .rows_cnt(cnt_m));

    coo_row_dispatcher #(.DATA_W(32), .IDX_W(16), .NUM_PES(4), .FIFO_DEPTH(8), .MODE(1), .CNT_W(32)) u_rr (
        .clk(clk), .rst(rst), .in_valid(iv_r), .in_ready(ir_r), .in_val(ival_r), .in_row(irow_r),
        .in_col(icol_r), .in_last(il_r), .out_valid(ov_r), .out_ready(ordy_r), .out_val(oval_r),
        .out_row(orow_r), .out_col(ocol_r), .out_row_last(orl_r), .out_stream_last(osl_r),
        .done(done_r), .err_order(err_r), .rows_cnt(cnt_r));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pop_chk(input int d, input int p, input exp_t obs);
        exp_t e;
        int   q;
        q = d * 4 + p;
        n_assert++;
        assert (sbq[q].size() > 0) else begin
            n_fail++;
            $error("FAIL unexpected_out_d%0d_pe%0d observed=%0h expected=none", d, p, obs);
        end
        if (sbq[q].size() > 0) begin
            e = sbq[q].pop_front();
            chk($sformatf("out_d%0d_pe%0d", d, p), 128'(obs), 128'(e));
        end
    endtask

    // Output monitor: a beat is taken whenever valid and ready are both high at the edge
    always begin
        @(negedge clk);
        #1;
        for (int p = 0; p < 4; p++) begin
            if (ov_m[p] && ordy_m[p])
                pop_chk(0, p, '{val: oval_m[p*32 +: 32], row: orow_m[p*16 +: 16], col: ocol_m[p*16 +: 16],
                                rl: orl_m[p], sl: osl_m[p]});
            if (ov_r[p] && ordy_r[p])
                pop_chk(1, p, '{val: oval_r[p*32 +: 32], row: orow_r[p*16 +: 16], col: ocol_r[p*16 +: 16],
                                rl: orl_r[p], sl: osl_r[p]});
        end
    end

    task automatic set_in(input int d, input logic v, input logic [15:0] row, input logic [15:0] col,
                          input logic [31:0] val, input logic last);
        if (d == 0) begin
            iv_m = v; irow_m = row; icol_m = col; ival_m = val; il_m = last;
        end else begin
            iv_r = v; irow_r = row; icol_r = col; ival_r = val; il_r = last;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge
    task automatic put(input int d, input logic [15:0] row, input logic [15:0] col,
                       input logic [31:0] val, input logic last);
        logic got;
        got = 1'b0;
        set_in(d, 1'b1, row, col, val, last);
        for (int c = 0; c < 300; c++) begin
            #1;
            got = (d == 0) ? ir_m : ir_r;
            @(negedge clk);
            if (got) break;
        end
        set_in(d, 1'b0, 16'd0, 16'd0, 32'd0, 1'b0);
        chk($sformatf("in_accept_d%0d", d), 128'(got), 128'(1));
    endtask

    // Reference model: target PE and tags for each element of the stream in s_row
    task automatic plan(input int d, input int n);
        int rr;
        rr = 0;
        for (int i = 0; i < n; i++) begin
            if (d == 0) begin
                pe_arr[i] = s_row[i] % 4;
            end else begin
                if (i > 0 && s_row[i] != s_row[i-1]) rr = (rr + 1) % 4;
                pe_arr[i] = rr;
            end
            e_arr[i].val = 32'hC0DE_0000 + 32'(seq + i);
            e_arr[i].row = 16'(s_row[i]);
            e_arr[i].col = 16'((seq + i) * 3 + 1);
            e_arr[i].sl  = (i == n - 1);
            e_arr[i].rl  = (i == n - 1) ? 1'b1 : (s_row[i+1] != s_row[i]);
        end
        seq += n;
    endtask

    task automatic drive_elem(input int d, input int i, input logic last);
        sbq[d*4 + pe_arr[i]].push_back(e_arr[i]);
        put(d, e_arr[i].row, e_arr[i].col, e_arr[i].val, last);
    endtask

    task automatic send_stream(input int d, input int n);
        plan(d, n);
        for (int i = 0; i < n; i++) drive_elem(d, i, i == n - 1);
    endtask

    task automatic wait_done(input int d, input string tag);
        logic dn;
        dn = 1'b0;
        for (int c = 0; c < 300; c++) begin
            #1;
            dn = (d == 0) ? done_m : done_r;
            @(negedge clk);
            if (dn) break;
        end
        chk(tag, 128'(dn), 128'(1));
    endtask

    task automatic chk_sb_empty(input int d, input string tag);
        for (int p = 0; p < 4; p++) chk($sformatf("%s_pe%0d", tag, p), 128'(sbq[d*4+p].size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_in(0, 1'b0, 16'd0, 16'd0, 32'd0, 1'b0);
        set_in(1, 1'b0, 16'd0, 16'd0, 32'd0, 1'b0);
        ordy_m = 4'hF;
        ordy_r = 4'hF;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", 128'(ir_m), 128'(0));
        chk("rst_out_valid", 128'(ov_m), 128'(0));
        chk("rst_done", 128'(done_m), 128'(0));
        chk("rst_rows_cnt", 128'(cnt_m), 128'(0));
        chk("rst_err", 128'(err_m), 128'(0));
        chk("rst_out_val", 128'(oval_m), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_in_ready", 128'(ir_m), 128'(1));
        @(negedge clk);

        // MODE 0, rows 0,0,1,5
        s_row[0] = 0; s_row[1] = 0; s_row[2] = 1; s_row[3] = 5;
        send_stream(0, 4);
        wait_done(0, "t1_done");
        chk("t1_rows_cnt", 128'(cnt_m), 128'(3));
        chk("t1_err", 128'(err_m), 128'(0));
        chk_sb_empty(0, "t1_sb");

        // MODE 1, rows 7,7,9,9,9,12
        s_row[0] = 7; s_row[1] = 7; s_row[2] = 9; s_row[3] = 9; s_row[4] = 9; s_row[5] = 12;
        send_stream(1, 6);
        wait_done(1, "t2_done");
        chk("t2_rows_cnt", 128'(cnt_r), 128'(3));
        chk_sb_empty(1, "t2_sb");

        // Back-pressure on PE0: 10 elements of row 0
        for (int i = 0; i < 10; i++) s_row[i] = 0;
        plan(0, 10);
        ordy_m = 4'hE;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                set_in(0, 1'b1, e_arr[i].row, e_arr[i].col, e_arr[i].val, 1'b1);
                repeat (3) @(negedge clk);
                #1;
                chk("t3_in_ready_full", 128'(ir_m), 128'(0));
                chk("t3_pe0_valid", 128'(ov_m[0]), 128'(1));
                @(negedge clk);
                ordy_m = 4'hF;
            end
            drive_elem(0, i, i == 9);
        end
        wait_done(0, "t3_done");
        chk("t3_rows_cnt", 128'(cnt_m), 128'(4));
        chk_sb_empty(0, "t3_sb");

        // Single-element stream
        s_row[0] = 6;
        send_stream(0, 1);
        k = 0;
        #1;
        while (!done_m && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("t4_done_latency_ok", 128'(k <= 3), 128'(1));
        @(negedge clk);
        chk("t4_rows_cnt", 128'(cnt_m), 128'(5));
        chk_sb_empty(0, "t4_sb");

        // Descending rows set the sticky order error
        s_row[0] = 3; s_row[1] = 2;
        send_stream(0, 2);
        wait_done(0, "t5_done");
        chk("t5_err", 128'(err_m), 128'(1));
        chk("t5_rows_cnt", 128'(cnt_m), 128'(7));
        s_row[0] = 4;
        send_stream(0, 1);
        wait_done(0, "t5b_done");
        chk("t5b_err_sticky", 128'(err_m), 128'(1));
        chk("t5b_rows_cnt", 128'(cnt_m), 128'(8));
        chk_sb_empty(0, "t5_sb");

        // Reset while FIFOs hold data
        ordy_m = 4'h0;
        put(0, 16'd1, 16'd100, 32'hDEAD_0001, 1'b0);
        put(0, 16'd1, 16'd101, 32'hDEAD_0002, 1'b0);
        put(0, 16'd1, 16'd102, 32'hDEAD_0003, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("t6_pre_valid_pe1", 128'(ov_m[1]), 128'(1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_out_valid", 128'(ov_m), 128'(0));
        chk("t6_rst_in_ready", 128'(ir_m), 128'(0));
        chk("t6_rst_done", 128'(done_m), 128'(0));
        for (int p = 0; p < 4; p++) sbq[p].delete();
        @(negedge clk);
        rst = 1'b0;
        ordy_m = 4'hF;
        @(negedge clk);
        #1;
        chk("t6_rows_cnt", 128'(cnt_m), 128'(0));
        chk("t6_done", 128'(done_m), 128'(0));
        chk("t6_err", 128'(err_m), 128'(0));
        chk("t6_out_valid", 128'(ov_m), 128'(0));
        chk("t6_in_ready", 128'(ir_m), 128'(1));
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/coo_row_dispatcher.md
# coo_row_dispatcher

Synthesizable successor to the test-bench CSV feeder. It accepts a row-sorted COO triple stream (val, row, col, last) over ready/valid and detects row boundaries with a one-element look-ahead register. It then distributes whole rows to NUM_PES per-PE FIFOs, tagging the last element of each row and of the stream. It sits between the input loader and the MatRaptor PE array, replacing the single-PE direct feed.

## Interface
- DATA_W, 32: value width (raw float bits, passed through untouched)
- IDX_W, 16: row/col index width
- NUM_PES, 4: output channels; power of two, ≥1
- FIFO_DEPTH, 8: entries per PE FIFO; power of two, ≥2
- MODE, 0: 0 = row-modulo (PE = row[log2(NUM_PES)-1:0], 0 if NUM_PES==1); 1 = round-robin, advancing on each new row
- CNT_W, 32: row counter width
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid / in_ready  in/out  1  input handshake
- in_val  in  DATA_W;  in_row, in_col  in  IDX_W;  in_last  in  1  (final element of stream)
- out_valid / out_ready  out/in  NUM_PES  per-PE handshake
- out_val  out  NUM_PES*DATA_W;  out_row, out_col  out  NUM_PES*IDX_W  (PE p at slice p)
- out_row_last, out_stream_last  out  NUM_PES  tags on current head element
- done  out  1  stream fully accepted and all FIFOs drained
- err_order  out  1  sticky: row index decreased within a stream
- rows_cnt  out  CNT_W  row_last elements pushed, wraps

## Operation
- Hold register H = {elem, target PE, valid}. An element leaves H (pushed to FIFO[target]) only when its successor is accepted or the stream ends.
- row_last of pushed element = (successor.row != H.row) or pushing in FLUSH.
- Target on capture: MODE 0 from row bits. MODE 1: rr pointer advances (mod NUM_PES) when captured row != previous captured row; first row of each stream goes to PE 0.
- States:
  - EMPTY: in_ready=1. Accept → HOLD, or FLUSH if in_last.
  - HOLD: in_ready = !full[H.target]. Accept → push H, capture new, stay HOLD; go FLUSH if in_last.
  - FLUSH: in_ready=0. Push H with row_last=1, stream_last=1 when !full[H.target] → DRAIN.
  - DRAIN: in_ready=0. All FIFOs empty → DONE.
  - DONE: done=1, in_ready=1. Accept → as EMPTY (rr reset to 0, done drops next cycle).
- err_order is set when an accepted row < H.row while H is valid; the element is still dispatched normally. Only rst clears err_order.
- rows_cnt increments on every push with row_last=1.

## Timing
- During and after rst: state EMPTY, H invalid, rr=0, FIFOs empty. All outputs 0 (including in_ready while rst=1, done, err_order, rows_cnt, out_*); in_ready=1 from the first cycle after release.
- Push into a FIFO occurs on the accepting edge. out_valid[p] rises the following cycle (registered FIFO, no fall-through).
- Minimum input-to-output latency: 2 cycles after the successor's acceptance. The final element appears 1 cycle after the FLUSH push.
- Steady state: 1 element/cycle while the target FIFO is not full.
- FIFO full: in_ready=0 in HOLD; back-pressure is per target only. Other PEs keep draining.
- Simultaneous push and pop on a full FIFO: pop frees a slot only on the next cycle (full is registered), so in_ready stays 0 that cycle.
- Pointers wrap modulo FIFO_DEPTH; count uses log2(FIFO_DEPTH)+1 bits.
- Single-element stream (in_last on first beat): EMPTY→FLUSH→DRAIN→DONE, one push with both tags set.
- Reset mid-stream discards H and all FIFO contents immediately.

## Structure
- Package coo_pkg: coo_elem_t struct {val, row, col, row_last, stream_last}, disp_state_t enum {EMPTY, HOLD, FLUSH, DRAIN, DONE}, mode localparams MODE_MOD=0, MODE_RR=1.
- Sub-module coo_fifo (coo_elem_t payload, FIFO_DEPTH, registered full/empty), instantiated NUM_PES times in a generate loop.

## Test plan
- NUM_PES=4, MODE 0, rows 0,0,1,5 (last on row 5), out_ready=1 → PE0 gets two elements (row_last on the second). PE1 gets row 1 with row_last. The row-5 element goes to PE1 with row_last and stream_last. done rises once the FIFOs are empty; rows_cnt=3.
- MODE 1, rows 7,7,9,9,9,12 → rows 7/9/12 go to PE0/1/2; the row_last flags fall on elements 2, 5 and 6.
- Hold out_ready[0]=0 while sending 10 elements of row 0, FIFO_DEPTH=8 → in_ready drops once FIFO0 is full and the held element is waiting. Releasing out_ready delivers all 10 in order with no loss.
- Single element with in_last=1 → one output carrying row_last=stream_last=1; done asserted by cycle 4.
- Rows 3 then 2 → err_order=1 and it stays set; both elements are still delivered. A second stream started after DONE keeps err_order=1.
- Assert rst while the FIFOs hold data → all out_valid=0, in_ready=0 during reset, rows_cnt=0 and done=0 afterwards.
